// File: rtl/imm_ext_pipe.sv
// imm_ext_pipe: extends an IMM_W-bit immediate to DATA_W bits under a 3-bit mode.
// Each result goes into a 2-entry output FIFO together with a sideband tag and an
// illegal-mode flag. The unit also keeps a saturating count of accepted illegal
// requests and supports a synchronous flush.
module imm_ext_pipe #(
  parameter int IMM_W     = 16,
  parameter int DATA_W    = 32,
  parameter int TAG_W     = 4,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IMM_W-1:0]     in_imm,
  input  logic [2:0]           in_op,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  localparam logic [2:0] OP_ZERO   = 3'b000;
  localparam logic [2:0] OP_SIGNED = 3'b001;
  localparam logic [2:0] OP_HIGH   = 3'b010;
  localparam logic [2:0] OP_BRANCH = 3'b011;
  localparam logic [2:0] OP_ZHIGH  = 3'b100;

  // Returns {illegal, extended value}; illegal modes produce a zero value.
  function automatic logic [DATA_W:0] extend(input logic [IMM_W-1:0] imm,
                                             input logic [2:0]       op);
    logic signed [DATA_W-1:0] s;
    logic        [DATA_W-1:0] z;
    logic        [DATA_W:0]   res;
    s   = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    z   = {{(DATA_W-IMM_W){1'b0}}, imm};
    res = '0;
    case (op)
      OP_ZERO:   res = {1'b0, z};
      OP_SIGNED: res = {1'b0, s};
      OP_HIGH:   res = {1'b0, imm, {(DATA_W-IMM_W){1'b0}}};
      OP_BRANCH: res = {1'b0, s[DATA_W-3:0], 2'b00};
      OP_ZHIGH:  res = {1'b0, {(DATA_W-IMM_W){1'b1}}, imm};
      default:   res = {1'b1, {DATA_W{1'b0}}};
    endcase
    return res;
  endfunction

  // Saturating increment: holds at all-ones.
  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic [DATA_W:0]      w_ext_p0;
  logic                 w_push;
  logic                 w_pop;

  logic [DATA_W-1:0]    r_data_p1 [2];
  logic [TAG_W-1:0]     r_tag_p1  [2];
  logic                 r_err_p1  [2];
  logic [1:0]           r_count;
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [ERR_CNT_W-1:0] r_err_cnt;

  // Input stage: combinational extension of the incoming immediate.
  assign w_ext_p0  = extend(in_imm, in_op);

  // in_ready depends only on the registered occupancy, never on out_ready.
  assign in_ready  = (r_count != 2'd2);
  assign out_valid = (r_count != 2'd0);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  assign out_data  = out_valid ? r_data_p1[r_rd_ptr] : '0;
  assign out_tag   = out_valid ? r_tag_p1[r_rd_ptr]  : '0;
  assign out_err   = out_valid ? r_err_p1[r_rd_ptr]  : 1'b0;
  assign err_cnt   = r_err_cnt;

  // Buffer stage: payload storage, written on every accepted push (no reset needed).
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_data_p1[r_wr_ptr] <= w_ext_p0[DATA_W-1:0];
      r_tag_p1[r_wr_ptr]  <= in_tag;
      r_err_p1[r_wr_ptr]  <= w_ext_p0[DATA_W];
    end
  end

  // FIFO control: occupancy, pointers and the illegal-request counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count   <= 2'd0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
      r_err_cnt <= '0;
    end else if (flush) begin
      r_count   <= 2'd0;
      r_wr_ptr  <= 1'b0;
      r_rd_ptr  <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_ext_p0[DATA_W]) r_err_cnt <= sat_inc(r_err_cnt);
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe: table of single-request vectors plus
// hand-written sequences for backpressure, illegal saturation, flush and reset.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        rstn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_imm;
  logic [2:0]  in_op;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        out_err;
  logic [7:0]  err_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  imm_ext_pipe #(.IMM_W(16), .DATA_W(32), .TAG_W(4), .ERR_CNT_W(8)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_imm(in_imm), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_err(out_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] imm;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_idle();
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    logic [7:0] exp_cnt;
    int got;
    int src;
    logic pushed, popped;
    logic [31:0] bp_exp [3];

    vecs[0]  = '{3'b001, 16'h8001, 32'hFFFF8001, 1'b0};
    vecs[1]  = '{3'b010, 16'h1234, 32'h12340000, 1'b0};
    vecs[2]  = '{3'b011, 16'hFFFF, 32'hFFFFFFFC, 1'b0};
    vecs[3]  = '{3'b100, 16'h00F0, 32'hFFFF00F0, 1'b0};
    vecs[4]  = '{3'b000, 16'h8001, 32'h00008001, 1'b0};
    vecs[5]  = '{3'b001, 16'h7FFF, 32'h00007FFF, 1'b0};
    vecs[6]  = '{3'b011, 16'h8000, 32'hFFFE0000, 1'b0};
    vecs[7]  = '{3'b011, 16'h4000, 32'h00010000, 1'b0};
    vecs[8]  = '{3'b010, 16'hFFFF, 32'hFFFF0000, 1'b0};
    vecs[9]  = '{3'b100, 16'hFFFF, 32'hFFFFFFFF, 1'b0};
    vecs[10] = '{3'b101, 16'hABCD, 32'h00000000, 1'b1};
    vecs[11] = '{3'b110, 16'hABCD, 32'h00000000, 1'b1};
    vecs[12] = '{3'b111, 16'hABCD, 32'h00000000, 1'b1};

    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_imm = '0; in_op = '0; in_tag = '0;
    out_ready = 1'b1;
    repeat (2) step();
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_tag", {28'd0, out_tag}, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
    rstn = 1'b1;
    step();

    // Single request, 1-cycle latency, then empty.
    in_valid = 1'b1; in_op = 3'b001; in_imm = 16'h8001; in_tag = 4'd3;
    step();
    push_idle();
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_data", out_data, 32'hFFFF8001);
    chk("lat_tag", {28'd0, out_tag}, 32'd3);
    chk("lat_err", {31'd0, out_err}, 32'd0);
    step();
    chk("lat_empty", {31'd0, out_valid}, 32'd0);

    // Table vectors back-to-back, one per cycle.
    for (int i = 0; i < 13; i++) begin
      in_valid = 1'b1; in_op = vecs[i].op; in_imm = vecs[i].imm; in_tag = 4'(i);
      step();
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("vec%0d_data", i), out_data, vecs[i].exp_data);
      chk($sformatf("vec%0d_tag", i), {28'd0, out_tag}, 32'(i));
      chk($sformatf("vec%0d_err", i), {31'd0, out_err}, {31'd0, vecs[i].exp_err});
    end
    push_idle();
    step();
    chk("vec_cnt", {24'd0, err_cnt}, 32'd3);
    chk("vec_drained", {31'd0, out_valid}, 32'd0);

    // Backpressure: two accepted, third held by the source.
    bp_exp[0] = 32'd1; bp_exp[1] = 32'd2; bp_exp[2] = 32'd3;
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'b000; in_imm = 16'd1; in_tag = 4'd1;
    step();
    in_imm = 16'd2; in_tag = 4'd2;
    step();
    in_imm = 16'd3; in_tag = 4'd3;
    chk("bp_full_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("bp_hold_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_hold_data", out_data, 32'd1);
    out_ready = 1'b1;
    got = 0; src = 2;
    for (int c = 0; c < 20 && got < 3; c++) begin
      pushed = in_valid && in_ready;
      popped = out_valid && out_ready;
      if (popped) begin
        chk($sformatf("bp_order%0d", got), out_data, bp_exp[got]);
        chk($sformatf("bp_tag%0d", got), {28'd0, out_tag}, bp_exp[got]);
        got++;
      end
      step();
      if (pushed) begin
        src++;
        in_valid = 1'b0;
      end
    end
    chk("bp_count", 32'(got), 32'd3);
    chk("bp_src", 32'(src), 32'd3);
    chk("bp_nodup", {31'd0, out_valid}, 32'd0);

    // Illegal mode repeated until the counter saturates.
    exp_cnt = 8'd3;
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; in_op = 3'b111; in_imm = 16'hABCD; in_tag = 4'hA;
      step();
      exp_cnt = (exp_cnt == 8'hFF) ? exp_cnt : exp_cnt + 8'd1;
      chk("ill_data", out_data, 32'd0);
      chk("ill_err", {31'd0, out_err}, 32'd1);
      chk("ill_cnt", {24'd0, err_cnt}, {24'd0, exp_cnt});
    end
    push_idle();
    step();
    chk("ill_sat", {24'd0, err_cnt}, 32'd255);

    // Flush with a full buffer and a pending illegal request.
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'b000; in_imm = 16'h0011; in_tag = 4'd1;
    step();
    in_imm = 16'h0022; in_tag = 4'd2;
    step();
    chk("fl_full", {31'd0, in_ready}, 32'd0);
    flush = 1'b1; in_op = 3'b111; in_imm = 16'h0033;
    step();
    push_idle();
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_ready", {31'd0, in_ready}, 32'd1);
    chk("fl_cnt", {24'd0, err_cnt}, 32'd255);
    step();
    chk("fl_dropped", {31'd0, out_valid}, 32'd0);

    // Flush while a push is actually accepted: the push must vanish.
    in_valid = 1'b1; in_op = 3'b000; in_imm = 16'h0044; in_tag = 4'd4;
    step();
    flush = 1'b1; in_op = 3'b001; in_imm = 16'h0055; in_tag = 4'd5;
    step();
    push_idle();
    chk("fl1_valid", {31'd0, out_valid}, 32'd0);
    step();
    chk("fl1_dropped", {31'd0, out_valid}, 32'd0);
    in_valid = 1'b1; in_op = 3'b000; in_imm = 16'h0066; in_tag = 4'd6;
    step();
    push_idle();
    chk("fl_after_data", out_data, 32'h00000066);
    chk("fl_after_tag", {28'd0, out_tag}, 32'd6);
    out_ready = 1'b1;
    step();
    chk("fl_after_empty", {31'd0, out_valid}, 32'd0);

    // Asynchronous reset in the middle of a full, stalled buffer.
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 3'b111; in_imm = 16'h0001; in_tag = 4'd1;
    step();
    in_op = 3'b000; in_imm = 16'h0002;
    step();
    push_idle();
    chk("mr_full", {31'd0, in_ready}, 32'd0);
    #2 rstn = 1'b0;
    #1;
    chk("mr_valid", {31'd0, out_valid}, 32'd0);
    chk("mr_ready", {31'd0, in_ready}, 32'd1);
    chk("mr_cnt", {24'd0, err_cnt}, 32'd0);
    chk("mr_data", out_data, 32'd0);
    #1 rstn = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1; in_op = 3'b001; in_imm = 16'h8001; in_tag = 4'd5;
    step();
    push_idle();
    chk("mr_push_valid", {31'd0, out_valid}, 32'd1);
    chk("mr_push_data", out_data, 32'hFFFF8001);
    chk("mr_push_tag", {28'd0, out_tag}, 32'd5);
    step();
    chk("mr_push_empty", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
Parametrised, pipelined immediate-extension unit for the pipelined datapath. It extends an IMM_W-bit instruction immediate to DATA_W bits under a 3-bit mode. Results pass through a 2-entry output buffer with valid/ready handshakes on both sides. A per-entry tag travels with each result so the ID stage can realign results with instructions. It adds a branch-offset mode, illegal-mode detection, a saturating error counter and a pipeline flush.

Parameters:
IMM_W, 16, immediate input width (>=2, <=DATA_W/2 for HIGH mode)
DATA_W, 32, extended output width
TAG_W, 4, width of the sideband tag carried with each result
ERR_CNT_W, 8, width of the saturating illegal-mode counter

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
flush  in  1  synchronous flush, drops all buffered entries
in_valid  in  1  request valid
in_ready  out  1  unit can accept a request this cycle
in_imm  in  IMM_W  immediate field
in_op  in  3  extension mode
in_tag  in  TAG_W  sideband tag
out_valid  out  1  head entry valid
out_ready  in  1  consumer accepts head entry
out_data  out  DATA_W  extended result
out_tag  out  TAG_W  tag of head entry
out_err  out  1  head entry was an illegal mode
err_cnt  out  ERR_CNT_W  count of accepted illegal-mode requests, saturating

Behaviour:
- Modes, with S = in_imm sign-extended and Z = in_imm zero-extended:
  - 3'b000 ZERO: Z.
  - 3'b001 SIGNED: S.
  - 3'b010 HIGHPOS: in_imm in bits [DATA_W-1 -: IMM_W], all other bits 0.
  - 3'b011 BRANCH: S shifted left 2; the top two bits of S are discarded.
  - 3'b100 ZERO_HIGHHALF: Z in the lower IMM_W bits, upper bits 1 (used for ANDI-style masks).
  - 3'b101..3'b111 illegal: result 0, err=1.
- Extension is combinational on the input side and is written into the buffer; no latch on any path.
- Buffer: 2-entry FIFO with count in {0,1,2}, write pointer and read pointer.
  - Push = in_valid & in_ready.
  - Pop = out_valid & out_ready.
- in_ready = (count != 2). It is derived from registered state only; there is no combinational path from out_ready.
- out_valid = (count != 0). out_data, out_tag and out_err come from the head entry, are registered, and are stable while out_valid & !out_ready.
- Latency: a request accepted at edge N is visible at out_valid/out_data after edge N (1 cycle) when the buffer was empty.
- Throughput: 1 per cycle while the consumer is ready.
- Push and pop in the same cycle: count unchanged, order preserved. At count 2 a push is impossible.
- Pointers are 1 bit and wrap naturally.
- err_cnt increments on each accepted illegal-mode push and holds at all-ones. It is not cleared by flush.
- flush: on the next edge count := 0 and pointers := 0.
  - Any push in the flush cycle is dropped and err_cnt does not count it.
  - Any pop in the flush cycle is still considered consumed.
- Reset (asynchronous assert, any time including mid-transfer):
  - count = 0, pointers = 0, err_cnt = 0.
  - Buffer contents are don't-care. Outputs out_data, out_tag and out_err read 0 while count = 0 after reset.
  - in_ready = 1 and out_valid = 0 during and after reset.
  - Deassertion is treated as synchronous to clk by the top level.

Test Plan:
- Reset then op=001, imm=16'h8001, tag=3 for one cycle, out_ready=1 -> next cycle out_valid=1, out_data=32'hFFFF8001, out_tag=3, out_err=0. The following cycle out_valid=0.
- Back-to-back with out_ready=1: op=010 imm=16'h1234, then op=011 imm=16'hFFFF, then op=100 imm=16'h00F0 -> consecutive outputs 32'h12340000, 32'hFFFFFFFC, 32'hFFFF00F0, one per cycle.
- Backpressure: out_ready=0, push imm=1,2,3 (op=000) on consecutive cycles -> in_ready=0 after 2 accepted and the third is held by the source. Release out_ready -> outputs 1,2,3 in order with no loss or duplication.
- Illegal mode: op=3'b111, imm=16'hABCD pushed 300 times with ERR_CNT_W=8 -> each out_data=0 and out_err=1. err_cnt stops at 255.
- Flush: buffer holds 2 entries, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, dropped input never appears, err_cnt unchanged.
- Reset mid-operation: buffer full and out_ready=0, pulse rstn low between edges -> immediately out_valid=0, in_ready=1, err_cnt=0. The first push after release emerges correctly after 1 cycle.
